window_3x3_gen: RTL and testbench

//   Builds a 3x3 pixel neighbourhood from a raster 8-bit stream, one pixel per de cycle.

---
 rtl/window_3x3_gen_if.sv | 27 ++
 rtl/window_3x3_gen.sv | 101 ++++++++++
 tb/tb_window_3x3_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/window_3x3_gen_if.sv
// window_3x3_gen_if: raster pixel stream in, 3x3 window plus delayed syncs out
// Ports: master drives vsync_in/hsync_in/de_in/data_in and observes the window;
// slave (the generator) consumes the stream and drives data11..data33, vsync_out, hsync_out, de_out.
interface window_3x3_gen_if #(
  parameter int DATA_W = 8
);
  logic              vsync_in;
  logic              hsync_in;
  logic              de_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data11, data12, data13;
  logic [DATA_W-1:0] data21, data22, data23;
  logic [DATA_W-1:0] data31, data32, data33;
  logic              vsync_out;
  logic              hsync_out;
  logic              de_out;
  modport master (
    output vsync_in, hsync_in, de_in, data_in,
    input  data11, data12, data13, data21, data22, data23, data31, data32, data33,
    input  vsync_out, hsync_out, de_out
  );
  modport slave (
    input  vsync_in, hsync_in, de_in, data_in,
    output data11, data12, data13, data21, data22, data23, data31, data32, data33,
    output vsync_out, hsync_out, de_out
  );
endinterface

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: 3x3 neighbourhood from a raster stream, border replication, fixed 2-clk latency
// Ports: clk pixel clock; rst_n asynchronous active-low reset;
// s (slave): vsync_in/hsync_in/de_in/data_in stream in; data11..data33 window
// (row 1 oldest line, col 1 oldest pixel) and vsync_out/hsync_out/de_out delayed 2 clk.
module window_3x3_gen #(
  parameter int IMG_WIDTH = 1280,
  parameter int DATA_W    = 8
) (
  input logic             clk,
  input logic             rst_n,
  window_3x3_gen_if.slave s
);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(IMG_WIDTH - 1);
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic de_d, vs_d, hs_seen, de_rise, de_fall, vs_rise, new_line;
  logic [AW-1:0] col_cnt, addr;
  logic [1:0] line_cnt, lc1;
  logic v1, first1, vs1, hs1, vs2, hs2, de2;
  logic [DATA_W-1:0] pix1, rd1, rd2, n1, n2, n3;
  logic [2:0][DATA_W-1:0] w1, w2, w3;
  // A de rising edge opens a new line only once hsync (or a frame start) has been
  // seen since the last pixel; otherwise it resumes a stalled line where it left off.
  always_comb begin
    de_rise  = s.de_in & ~de_d;
    de_fall  = ~s.de_in & de_d;
    vs_rise  = s.vsync_in & ~vs_d;
    new_line = de_rise & hs_seen;
    addr     = new_line ? '0 : col_cnt;
    n3       = pix1;
    n2       = (lc1 == 2'd0) ? pix1 : rd1;
    n1       = (lc1 == 2'd2) ? rd2 : n2;
  end
  // Line buffers: read-before-write, LB2 takes the line LB1 held before.
  always_ff @(posedge clk) begin
    if (s.de_in) begin
      lb1[addr] <= s.data_in;
      lb2[addr] <= lb1[addr];
      rd1       <= lb1[addr];
      rd2       <= lb2[addr];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d     <= 1'b0;
      vs_d     <= 1'b0;
      hs_seen  <= 1'b1;
      col_cnt  <= '0;
      line_cnt <= '0;
      lc1      <= '0;
      v1       <= 1'b0;
      first1   <= 1'b0;
      vs1      <= 1'b0;
      hs1      <= 1'b0;
      vs2      <= 1'b0;
      hs2      <= 1'b0;
      de2      <= 1'b0;
      pix1     <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
    end else begin
      de_d    <= s.de_in;
      vs_d    <= s.vsync_in;
      hs_seen <= (s.hsync_in | vs_rise) ? 1'b1 : s.de_in ? 1'b0 : hs_seen;
      if (s.de_in) col_cnt <= (addr == LAST) ? addr : addr + AW'(1);
      if (vs_rise) line_cnt <= '0;
      else if (de_fall && line_cnt != 2'd2) line_cnt <= line_cnt + 2'd1;
      v1  <= s.de_in;
      vs1 <= s.vsync_in;
      hs1 <= s.hsync_in;
      if (s.de_in) begin
        pix1   <= s.data_in;
        lc1    <= line_cnt;
        first1 <= new_line;
      end
      vs2 <= vs1;
      hs2 <= hs1;
      de2 <= v1;
      // First pixel fills all columns; the plain shift then makes col1 = col2 on the second.
      if (v1) begin
        w1 <= first1 ? {3{n1}} : {n1, w1[2:1]};
        w2 <= first1 ? {3{n2}} : {n2, w2[2:1]};
        w3 <= first1 ? {3{n3}} : {n3, w3[2:1]};
      end
    end
  end
  assign s.data11    = w1[0];
  assign s.data12    = w1[1];
  assign s.data13    = w1[2];
  assign s.data21    = w2[0];
  assign s.data22    = w2[1];
  assign s.data23    = w2[2];
  assign s.data31    = w3[0];
  assign s.data32    = w3[1];
  assign s.data33    = w3[2];
  assign s.vsync_out = vs2;
  assign s.hsync_out = hs2;
  assign s.de_out    = de2;
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed frames with a scoreboard of expected 3x3 windows
module tb_window_3x3_gen;
  typedef struct {
    int          stamp;
    logic [71:0] e;
    logic [8:0]  m;
    bit          kv;
    logic [71:0] k;
    logic [8:0]  km;
    string       tag;
  } ent_t;
  logic clk, rst_n;
  int cyc, checks, errors;
  ent_t q[$];
  logic [7:0] img [4][8];
  logic [71:0] kexp [int];
  logic [8:0] kmsk [int];
  logic [71:0] last_e, w;
  logic [8:0] last_m;
  logic [2:0] hist0, hist1;
  int hv;
  window_3x3_gen_if #(.DATA_W(8)) bus ();
  window_3x3_gen #(.IMG_WIDTH(8), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  assign w = {bus.data11, bus.data12, bus.data13, bus.data21, bus.data22, bus.data23,
              bus.data31, bus.data32, bus.data33};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [71:0] mm(input logic [8:0] m);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction
  function automatic int cl(input int x);
    return (x > 7) ? 7 : x;
  endfunction
  function automatic logic [71:0] model(input int lf, input int c);
    int l1, l2, l3, c1, c2, c3;
    l3 = lf;
    l2 = (lf >= 1) ? lf - 1 : lf;
    l1 = (lf >= 2) ? lf - 2 : l2;
    c3 = cl(c);
    c2 = cl((c >= 1) ? c - 1 : 0);
    c1 = cl((c >= 2) ? c - 2 : 0);
    return {img[l1][c1], img[l1][c2], img[l1][c3], img[l2][c1], img[l2][c2], img[l2][c3],
            img[l3][c1], img[l3][c2], img[l3][c3]};
  endfunction
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    ent_t en;
    if (bus.de_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: got de_out=1 expected no pending pixel");
      end else begin
        en = q.pop_front();
        chk({en.tag, "_lat"}, 72'(cyc), 72'(en.stamp + 2));
        if (en.m != 9'h0) chk({en.tag, "_win"}, w & mm(en.m), en.e & mm(en.m));
        if (en.kv) chk({en.tag, "_const"}, w & mm(en.km), en.k & mm(en.km));
        last_e = en.e;
        last_m = en.m;
      end
    end else chk("hold", w & mm(last_m), last_e & mm(last_m));
    if (!rst_n) hv = 0;
    else begin
      if (hv >= 2) chk("sync_delay", 72'({bus.vsync_out, bus.hsync_out, bus.de_out}), 72'(hist1));
      hist1 = hist0;
      hist0 = {bus.vsync_in, bus.hsync_in, bus.de_in};
      hv++;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step();
    bus.de_in = 1'b0;
  endtask
  task automatic hpulse();
    idle();
    bus.hsync_in = 1'b1;
    idle();
    idle();
    bus.hsync_in = 1'b0;
    idle();
  endtask
  task automatic vpulse();
    idle();
    bus.vsync_in = 1'b1;
    idle();
    idle();
    bus.vsync_in = 1'b0;
    idle();
  endtask
  task automatic do_line(input int lf, input int ln, input int n, input int gap_after,
                         input logic [8:0] m, input string tag);
    ent_t en;
    hpulse();
    for (int c = 0; c < n; c++) begin
      step();
      bus.de_in   = 1'b1;
      bus.data_in = 8'(16 * ln + c);
      img[lf][cl(c)] = bus.data_in;
      en.stamp = cyc;
      en.e     = model(lf, c);
      en.m     = (c > 7) ? 9'h0 : m;
      en.kv    = kexp.exists(c);
      en.k     = en.kv ? kexp[c] : 72'h0;
      en.km    = en.kv ? kmsk[c] : 9'h0;
      en.tag   = $sformatf("%s_c%0d", tag, c);
      q.push_back(en);
      if (c == gap_after) repeat (3) idle();
    end
    kexp.delete();
    kmsk.delete();
  endtask
  initial begin
    checks = 0;
    errors = 0;
    hv = 0;
    last_e = '0;
    last_m = 9'h1ff;
    rst_n = 1'b0;
    bus.vsync_in = 1'b0;
    bus.hsync_in = 1'b0;
    bus.de_in = 1'b0;
    bus.data_in = 8'h0;
    repeat (3) step();
    chk("rst_window", w, 72'h0);
    chk("rst_syncs", 72'({bus.vsync_out, bus.hsync_out, bus.de_out}), 72'h0);
    rst_n = 1'b1;
    // Frame A: T1..T4
    vpulse();
    kexp[0] = 72'h000000_000000_000000; kmsk[0] = 9'h1ff;
    kexp[1] = 72'h000001_000001_000001; kmsk[1] = 9'h1ff;
    do_line(0, 0, 8, -1, 9'h1ff, "t2_l0");
    kexp[0] = 72'h000000_000000_101010; kmsk[0] = 9'h1ff;
    do_line(1, 1, 8, -1, 9'h1ff, "t3_l1");
    kexp[4] = 72'h020304_121314_222324; kmsk[4] = 9'h1ff;
    kexp[5] = 72'h030405_131415_232425; kmsk[5] = 9'h1ff;
    do_line(2, 2, 8, 3, 9'h1ff, "t1t4_l2");
    do_line(3, 3, 8, -1, 9'h1ff, "a_l3");
    // Frame B: T5 long line overwrites the last line-buffer entry
    vpulse();
    do_line(0, 0, 8, -1, 9'h1ff, "b_l0");
    do_line(1, 1, 10, -1, 9'h1ff, "t5_long");
    kexp[7] = {40'h0, 8'h19, 24'h0}; kmsk[7] = 9'h008;
    do_line(2, 2, 8, -1, 9'h03f, "t5_l2");
    // Frame C: T6 reset mid-line
    vpulse();
    do_line(0, 0, 8, -1, 9'h1ff, "c_l0");
    do_line(1, 1, 8, -1, 9'h1ff, "c_l1");
    do_line(2, 2, 4, -1, 9'h1ff, "c_l2");
    step();
    rst_n = 1'b0;
    bus.de_in = 1'b0;
    q.delete();
    last_e = '0;
    last_m = 9'h1ff;
    #1;
    chk("t6_rst_window", w, 72'h0);
    chk("t6_rst_syncs", 72'({bus.vsync_out, bus.hsync_out, bus.de_out}), 72'h0);
    repeat (3) idle();
    rst_n = 1'b1;
    kexp[3] = 72'h313233_313233_313233; kmsk[3] = 9'h1ff;
    do_line(0, 3, 8, -1, 9'h1ff, "t6_l3");
    hpulse();
    repeat (6) idle();
    chk("sb_drained", 72'(q.size()), 72'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
